block_sweep: RTL
================

BLOCK_SWEEP -- requirements
Module: block_sweep

Interface
REQ-001 Parameter: DWELL_W, 4, width of the dwell input.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: start  input  1  sweep request, sampled only in IDLE.
REQ-006 Port: dwell  input  DWELL_W  extra hold cycles per vector, sampled with start.
REQ-007 Port: o0, o1  input  1 each  outputs returned by the downstream block under test.
REQ-008 Port: i0, i1, s0, s1  output  1 each  registered stimulus to the downstream block.
REQ-009 Port: busy  output  1  high while in DRIVE or SAMPLE.
REQ-010 Port: done  output  1  one-cycle pulse at sweep end.
REQ-011 Port: result  output  32  captured responses, result[2k+1]=o0, result[2k]=o1 for vector k.
REQ-012 Port: err_cnt  output  5  count of vectors mismatching the golden model.
REQ-013 Port: pass  output  1  high when the last completed sweep had err_cnt==0.

Function
REQ-014 The FSM SHALL have states IDLE, DRIVE, SAMPLE, DONE.
REQ-015 IDLE with start=1 SHALL latch dwell, set idx=0, and clear result, err_cnt and pass.
REQ-016 IDLE with start=1 SHALL then enter DRIVE.
REQ-017 In DRIVE and SAMPLE, {i0,i1,s0,s1} SHALL equal idx[3:0], with i0 as the MSB.
REQ-018 DRIVE SHALL last dwell+1 cycles, counted by a down-counter loaded from the latched dwell.
REQ-019 DRIVE SHALL then enter SAMPLE.
REQ-020 SAMPLE SHALL last one cycle.
REQ-021 At the SAMPLE exit edge, the block SHALL store {o0,o1} into result slot idx.
REQ-022 At the SAMPLE exit edge, the block SHALL compare {o0,o1} to the golden {O0,O1} for idx and increment err_cnt on mismatch.
REQ-023 From SAMPLE with idx<15, the block SHALL set idx+1, reload the dwell counter and re-enter DRIVE.
REQ-024 From SAMPLE with idx==15, the block SHALL enter DONE.
REQ-025 Golden model: a=s1|i0, b=s0&i1, c=a^b.
REQ-026 Golden O0 SHALL be (a|b) when s0=1, else c.
REQ-027 Golden O1 SHALL be c when s1=1, else (a&b).
REQ-028 DONE SHALL last one cycle with done=1.
REQ-029 DONE SHALL set pass=(err_cnt==0 including the final compare) and return to IDLE.
REQ-030 Latency: done SHALL assert exactly 16*(dwell+2) cycles after the start-sampling edge.
REQ-031 start outside IDLE, including during DONE, SHALL be ignored without side effects.
REQ-032 dwell=0 SHALL give 1 DRIVE cycle.
REQ-033 dwell=2^DWELL_W-1 SHALL give 2^DWELL_W DRIVE cycles with no counter wrap.
REQ-034 err_cnt SHALL reach at most 16 and need no saturation logic.
REQ-035 In IDLE, i0/i1/s0/s1 SHALL hold 0.
REQ-036 result, err_cnt and pass SHALL hold until the next accepted start.
REQ-037 o0/o1 SHALL be sampled only at SAMPLE exit and be ignored at all other times.

Reset
REQ-038 rst_n low SHALL immediately force state IDLE.
REQ-039 rst_n low SHALL immediately force idx=0, the dwell counter to 0 and all outputs to 0.
REQ-040 Reset mid-sweep SHALL abort without a done pulse, leaving result, err_cnt and pass at 0.
REQ-041 After reset release, the first start SHALL run a complete sweep.

Structure
REQ-042 Package block_pkg SHALL hold the state enum, NUM_VEC=16 and the golden-model function.
REQ-043 The golden compare SHALL instantiate the existing block module as the single sub-module, driven by the registered i0/i1/s0/s1.

Verification
REQ-044 Real block looped back, dwell=0, start -> done 32 cycles later, err_cnt=0, pass=1, result[15:14]=2'b10 (idx7), result[29:28]=2'b11 (idx14), result[1:0]=2'b00.
REQ-045 dwell=3 -> each stimulus value held 5 cycles, done at cycle 80, pass=1.
REQ-046 o1 forced 0, dwell=0 -> err_cnt=7 (idx 1,3,5,9,11,13,14), pass=0.
REQ-047 Extra start pulses at cycles 5 and 31 of a dwell=0 sweep -> no restart, done still at cycle 32, then IDLE.
REQ-048 rst_n asserted while idx=5 -> all outputs 0 asynchronously, no done; a new start after release gives a full 32-cycle sweep with pass=1.
REQ-049 dwell=15 -> done at cycle 272, err_cnt=0.

Source files
------------

// File: rtl/block_sweep_pkg.sv
// Shared types, sizes and the golden response function for the exhaustive sweep.
package block_pkg;

    localparam int unsigned NUM_VEC = 16;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned ERR_W   = 5;
    localparam int unsigned RES_W   = 2 * NUM_VEC;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    typedef struct packed {
        logic i0;
        logic i1;
        logic s0;
        logic s1;
    } stim_t;

    // Reference response {O0,O1} of the block under test for one stimulus vector.
    function automatic logic [1:0] golden(input stim_t v);
        logic a;
        logic b;
        logic c;
        a = v.s1 | v.i0;
        b = v.s0 & v.i1;
        c = a ^ b;
        golden = {(v.s0 ? (a | b) : c), (v.s1 ? c : (a & b))};
    endfunction

endpackage

// File: rtl/block_sweep_if.sv
// Stimulus/response and status bundle between the sweeper and its environment.
interface block_sweep_if
    import block_pkg::*;
#(
    parameter int unsigned DWELL_W = 4
);
    logic               start;
    logic [DWELL_W-1:0] dwell;
    logic               o0;
    logic               o1;
    logic               i0;
    logic               i1;
    logic               s0;
    logic               s1;
    logic               busy;
    logic               done;
    logic [RES_W-1:0]   result;
    logic [ERR_W-1:0]   err_cnt;
    logic               pass;

    modport master (
        output start, dwell, o0, o1,
        input  i0, i1, s0, s1, busy, done, result, err_cnt, pass
    );

    modport slave (
        input  start, dwell, o0, o1,
        output i0, i1, s0, s1, busy, done, result, err_cnt, pass
    );
endinterface

// File: rtl/block_sweep_block.sv
// Combinational block under test, reused here as the golden reference.
module block
    import block_pkg::*;
(
    input  logic i0,
    input  logic i1,
    input  logic s0,
    input  logic s1,
    output logic o0_c,
    output logic o1_c
);
    assign {o0_c, o1_c} = golden(stim_t'({i0, i1, s0, s1}));
endmodule

// File: rtl/block_sweep.sv
// Walks all 16 input vectors through the downstream block, holding each for dwell+1
// cycles, then captures and checks the returned outputs against the golden block.
module block_sweep
    import block_pkg::*;
#(
    parameter int unsigned DWELL_W = 4
)(
    input  logic          clk,
    input  logic          rst_n,
    block_sweep_if.slave  bus
);
    localparam logic [1:0] IDLE   = 2'(S_IDLE);
    localparam logic [1:0] DRIVE  = 2'(S_DRIVE);
    localparam logic [1:0] SAMPLE = 2'(S_SAMPLE);
    localparam logic [1:0] DONE   = 2'(S_DONE);

    logic [1:0]         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    stim_t              stim_q, stim_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               pass_q, pass_d;
    logic [1:0]         gold_c;
    logic [1:0]         resp_c;

    // Golden outputs follow the registered stimulus, so they are settled in SAMPLE.
    block u_block (
        .i0   (stim_q.i0),
        .i1   (stim_q.i1),
        .s0   (stim_q.s0),
        .s1   (stim_q.s1),
        .o0_c (gold_c[1]),
        .o1_c (gold_c[0])
    );

    assign resp_c = {bus.o0, bus.o1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            dwell_q  <= '0;
            stim_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            err_q    <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            dwell_q  <= dwell_d;
            stim_q   <= stim_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            err_q    <= err_d;
            pass_q   <= pass_d;
        end
    end

    // Next-state and next-output logic; every output is registered from these.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        dwell_d  = dwell_q;
        stim_d   = stim_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        err_d    = err_q;
        pass_d   = pass_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dwell_d  = bus.dwell;
                    cnt_d    = bus.dwell;
                    idx_d    = '0;
                    stim_d   = '0;
                    result_d = '0;
                    err_d    = '0;
                    pass_d   = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q == '0) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end
            end
            SAMPLE: begin
                result_d[{idx_q, 1'b0} +: 2] = resp_c;
                if (resp_c != gold_c) begin
                    err_d = err_q + ERR_W'(1);
                end
                if (idx_q == IDX_W'(NUM_VEC - 1)) begin
                    stim_d  = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    stim_d  = stim_t'(idx_q + IDX_W'(1));
                    cnt_d   = dwell_q;
                    state_d = DRIVE;
                end
            end
            DONE: begin
                pass_d  = (err_q == '0);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.i0      = stim_q.i0;
    assign bus.i1      = stim_q.i1;
    assign bus.s0      = stim_q.s0;
    assign bus.s1      = stim_q.s1;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.result  = result_q;
    assign bus.err_cnt = err_q;
    assign bus.pass    = pass_q;
endmodule
